// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports and the single data-memory port that the
// dmem_arbiter sits between.
//   Requester 0 (processor M stage): req0, we0, addr0, wdata0 -> ack0, rdata0, stall0
//   Requester 1 (debug/loader port): req1, we1, addr1, wdata1 -> ack1, rdata1
//   Memory port: mem_wr_en, mem_addr, mem_wr_data -> mem_rd_data
// Modports:
//   slave  - the arbiter (consumes requests, drives acks and the memory port)
//   master - the surroundings (requesters plus the memory itself)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              stall0;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
        output ack0, ack1, rdata0, rdata1, stall0, mem_wr_en, mem_addr, mem_wr_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
        input  ack0, ack1, rdata0, rdata1, stall0, mem_wr_en, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one data memory (combinational read, write on clk edge) between the
// processor M stage (requester 0) and a debug/loader port (requester 1).
// Each access is IDLE -> ACCESS -> RESP: the request is latched on the grant
// edge, the memory is driven from the latched copy during ACCESS, and a
// one-cycle ack with registered read data is returned in RESP.  Ties are
// broken round-robin; requester 0 wins the first tie after reset.
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - dmem_arbiter_if.slave (requester ports and memory port)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic              lastServed;
    logic              curId;
    logic              curWe;
    logic [ADDR_W-1:0] curAddr;
    logic [DATA_W-1:0] curWdata;
    logic              wrEnReg;
    logic              ack0Reg;
    logic              ack1Reg;
    logic [DATA_W-1:0] rdata0Reg;
    logic [DATA_W-1:0] rdata1Reg;

    logic              grantId;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // Pick who would be granted if the FSM were in IDLE this cycle.  With
    // both requesting, the one not served last wins; with a single request
    // that requester wins (req1 alone selects 1, anything else selects 0).
    always_comb begin
        grantId  = 1'b0;
        selWe    = bus.we0;
        selAddr  = bus.addr0;
        selWdata = bus.wdata0;
        if (bus.req0 && bus.req1) begin
            grantId = ~lastServed;
        end else begin
            grantId = bus.req1;
        end
        if (grantId) begin
            selWe    = bus.we1;
            selAddr  = bus.addr1;
            selWdata = bus.wdata1;
        end
    end

    // Main FSM.  The write strobe is registered on the grant edge so it is
    // high for exactly the ACCESS cycle; ack is registered on the ACCESS exit
    // edge together with the read data so both are visible during RESP.
    // The read data is taken at the same edge as the memory write, so a write
    // returns the pre-write contents.  Last-served only moves when RESP
    // completes, so an aborted transaction does not disturb the rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lastServed <= 1'b1;
            curId      <= 1'b0;
            curWe      <= 1'b0;
            curAddr    <= '0;
            curWdata   <= '0;
            wrEnReg    <= 1'b0;
            ack0Reg    <= 1'b0;
            ack1Reg    <= 1'b0;
            rdata0Reg  <= '0;
            rdata1Reg  <= '0;
        end else begin
            wrEnReg <= 1'b0;
            ack0Reg <= 1'b0;
            ack1Reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        curId    <= grantId;
                        curWe    <= selWe;
                        curAddr  <= selAddr;
                        curWdata <= selWdata;
                        wrEnReg  <= selWe;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (curId) begin
                        rdata1Reg <= bus.mem_rd_data;
                        ack1Reg   <= 1'b1;
                    end else begin
                        rdata0Reg <= bus.mem_rd_data;
                        ack0Reg   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    lastServed <= curId;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The write strobe and acks are masked by rst so that a reset raised
    // during ACCESS stops the memory write on that same edge, and a reset
    // raised during RESP hides the pending ack.
    always_comb begin
        bus.mem_wr_en   = wrEnReg & ~rst;
        bus.mem_addr    = curAddr;
        bus.mem_wr_data = curWdata;
        bus.ack0        = ack0Reg & ~rst;
        bus.ack1        = ack1Reg & ~rst;
        bus.rdata0      = rdata0Reg;
        bus.rdata1      = rdata1Reg;
        bus.stall0      = bus.req0 & ~bus.ack0;
    end

    // curWe is kept as part of the latched request for visibility; the
    // registered write strobe already carries it into ACCESS.
    logic unusedCurWe;
    assign unusedCurWe = curWe;

endmodule
